// File: rtl/mw_load_store_unit.sv
// rtl/mw_load_store_unit.sv - MW-stage load/store unit: data-bus access, load formatting, writeback
module mw_load_store_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_mw,
  input  logic        st_mw,
  input  logic [2:0]  funct3_mw,
  input  logic [31:0] alu_result_mw,
  input  logic [31:0] rdata2_mw,
  input  logic [31:0] pc_mw,
  input  logic [4:0]  waddr_mw,
  input  logic        regwr_mw,
  input  logic [1:0]  wb_sel_mw,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ready,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        err;
  logic [31:0] ld_data_q;

  logic        mem_op;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        timeout;
  logic        wr_ok;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;
  logic [31:0] lane;
  logic [31:0] ld_fmt;
  logic [31:0] wb_val;

  assign mem_op  = ld_mw | st_mw;
  // funct3 100/101 are sized accesses only for loads; for stores they fall back to word
  assign is_byte = (funct3_mw == 3'b000) | (ld_mw & (funct3_mw == 3'b100));
  assign is_half = (funct3_mw == 3'b001) | (ld_mw & (funct3_mw == 3'b101));
  assign wr_ok   = regwr_mw & (waddr_mw != 5'd0);
  assign timeout = (cnt == 8'(MAX_WAIT - 1));

  always_comb begin
    misaligned = 1'b0;
    be_nx      = 4'b1111;
    wdata_nx   = rdata2_mw;
    if (is_byte) begin
      be_nx    = 4'b0001 << alu_result_mw[1:0];
      wdata_nx = {4{rdata2_mw[7:0]}};
    end else if (is_half) begin
      misaligned = alu_result_mw[0];
      be_nx      = alu_result_mw[1] ? 4'b1100 : 4'b0011;
      wdata_nx   = {2{rdata2_mw[15:0]}};
    end else begin
      misaligned = (alu_result_mw[1:0] != 2'b00);
    end
  end

  // MW registers are frozen during the access, so the address low bits still pick the lane
  assign lane = dbus_rdata >> {alu_result_mw[1:0], 3'b000};

  always_comb begin
    ld_fmt = dbus_rdata;
    case (funct3_mw)
      3'b000:  ld_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_fmt = {24'b0, lane[7:0]};
      3'b001:  ld_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_fmt = {16'b0, lane[15:0]};
      default: ld_fmt = dbus_rdata;
    endcase
  end

  always_comb begin
    case (wb_sel_mw)
      2'd1:    wb_val = ld_data_q;
      2'd2:    wb_val = pc_mw + 32'd4;
      default: wb_val = alu_result_mw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      err        <= 1'b0;
      ld_data_q  <= 32'd0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_wdata <= 32'd0;
      dbus_be    <= 4'd0;
      bus_err    <= 1'b0;
    end else begin
      state   <= state_nx;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op && !misaligned) begin
            dbus_req   <= 1'b1;
            dbus_we    <= st_mw;
            dbus_addr  <= {alu_result_mw[31:2], 2'b00};
            dbus_be    <= be_nx;
            dbus_wdata <= wdata_nx;
            cnt        <= 8'd0;
            err        <= 1'b0;
          end
        end
        ACCESS: begin
          if (dbus_ready) begin
            ld_data_q <= ld_fmt;
            dbus_req  <= 1'b0;
            dbus_we   <= 1'b0;
          end else if (timeout) begin
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            bus_err  <= 1'b1;
            err      <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    stall        = 1'b0;
    rf_we        = 1'b0;
    misalign_exc = 1'b0;
    rf_wdata     = wb_val;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            misalign_exc = 1'b1;
          end else begin
            stall    = 1'b1;
            state_nx = ACCESS;
          end
        end else begin
          rf_we = wr_ok;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (dbus_ready || timeout) state_nx = DONE;
      end
      DONE: begin
        // the held instruction retires here; never restart its access
        rf_we    = wr_ok & ld_mw & ~err;
        rf_wdata = ld_data_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      stall        = 1'b0;
      rf_we        = 1'b0;
      misalign_exc = 1'b0;
      state_nx     = IDLE;
    end
  end

  assign rf_waddr = waddr_mw;

endmodule

// File: tb/tb_mw_load_store_unit.sv
// tb/tb_mw_load_store_unit.sv - directed self-checking bench for mw_load_store_unit
module tb_mw_load_store_unit;
  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_mw, st_mw, regwr_mw;
  logic [2:0]  funct3_mw;
  logic [31:0] alu_result_mw, rdata2_mw, pc_mw;
  logic [4:0]  waddr_mw;
  logic [1:0]  wb_sel_mw;
  logic        dbus_req, dbus_we, dbus_ready;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        stall, rf_we, misalign_exc, bus_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  mw_load_store_unit #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .ld_mw(ld_mw), .st_mw(st_mw), .funct3_mw(funct3_mw),
    .alu_result_mw(alu_result_mw), .rdata2_mw(rdata2_mw), .pc_mw(pc_mw),
    .waddr_mw(waddr_mw), .regwr_mw(regwr_mw), .wb_sel_mw(wb_sel_mw),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_rdata(dbus_rdata),
    .dbus_ready(dbus_ready), .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  // expected outputs for the current cycle, written by the stimulus
  logic        e_on = 1'b0;
  logic        e_stall, e_rf_we, e_mis, e_berr, e_req, e_we, e_bus_zero;
  logic [31:0] e_addr, e_wdata, e_rf_wdata;
  logic [3:0]  e_be;
  logic [4:0]  e_rf_waddr;
  logic        e_lit_wd_on, e_lit_st_on, e_lit_be_on;
  logic [31:0] e_lit_wd, e_lit_wdata;
  int          e_lit_st;
  logic [3:0]  e_lit_be;

  int n_checks = 0;
  int n_err    = 0;
  int run      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_on) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("rf_we", 32'(rf_we), 32'(e_rf_we));
      chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
      chk("bus_err", 32'(bus_err), 32'(e_berr));
      chk("dbus_req", 32'(dbus_req), 32'(e_req));
      if (e_req) begin
        chk("dbus_we", 32'(dbus_we), 32'(e_we));
        chk("dbus_addr", dbus_addr, e_addr);
        chk("dbus_be", 32'(dbus_be), 32'(e_be));
        chk("dbus_wdata", dbus_wdata, e_wdata);
      end
      if (e_bus_zero) begin
        chk("rst_we", 32'(dbus_we), 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_be", 32'(dbus_be), 32'd0);
        chk("rst_wdata", dbus_wdata, 32'd0);
      end
      if (e_rf_we) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(e_rf_waddr));
        chk("rf_wdata", rf_wdata, e_rf_wdata);
      end
      if (e_lit_wd_on) chk("lit_rf_wdata", rf_wdata, e_lit_wd);
      if (e_lit_be_on) begin
        chk("lit_be", 32'(dbus_be), 32'(e_lit_be));
        chk("lit_wdata", dbus_wdata, e_lit_wdata);
      end
      if (stall === 1'b1) run++;
      else begin
        if (e_lit_st_on) chk("stall_len", 32'(run), 32'(e_lit_st));
        run = 0;
      end
    end
  end

  // reference rules: access size in bytes, lane masks by multiplication/shift
  function automatic int msize(input logic ld, input logic [2:0] f3);
    if (f3 == 3'b000 || (ld && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (ld && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] mbe(input int sz, input logic [31:0] a);
    return 4'(((1 << sz) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] mwd(input int sz, input logic [31:0] d);
    if (sz == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = msize(1'b1, f3);
    if (sz == 4) return rd;
    v = (rd >> (8 * int'(a[1:0]))) & ((32'h1 << (8 * sz)) - 32'h1);
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (32'h1 << (8 * sz - 1)))
      v = v - (32'h1 << (8 * sz));
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ld_mw = 0; st_mw = 0; funct3_mw = 0; alu_result_mw = 0; rdata2_mw = 0; pc_mw = 0;
    waddr_mw = 0; regwr_mw = 0; wb_sel_mw = 0; dbus_ready = 0; dbus_rdata = 0;
  endtask

  task automatic clr_exp();
    e_stall = 0; e_rf_we = 0; e_mis = 0; e_berr = 0; e_req = 0; e_we = 0; e_bus_zero = 0;
    e_addr = 0; e_wdata = 0; e_be = 0; e_rf_waddr = 0; e_rf_wdata = 0;
    e_lit_wd_on = 0; e_lit_st_on = 0; e_lit_be_on = 0;
    e_lit_wd = 0; e_lit_wdata = 0; e_lit_st = 0; e_lit_be = 0;
  endtask

  // n_ready = ACCESS cycle (1-based) that sees ready; 0 = never (timeout)
  task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d2, input logic [4:0] wa, input logic rw,
                        input int n_ready, input logic [31:0] rd,
                        input logic lw_on, input logic [31:0] lw_val, input int lst,
                        input logic lbe_on, input logic [3:0] lbe, input logic [31:0] lwd);
    int sz, nacc;
    logic to;
    clr_exp();
    idle_in();
    ld_mw = ld; st_mw = st; funct3_mw = f3; alu_result_mw = a; rdata2_mw = d2;
    waddr_mw = wa; regwr_mw = rw; wb_sel_mw = ld ? 2'd1 : 2'd0; pc_mw = 32'h40;
    sz = msize(ld, f3);
    if ((int'(a[1:0]) % sz) != 0) begin
      e_mis = 1;
      step();
      return;
    end
    e_stall = 1;
    step();
    to   = (n_ready == 0);
    nacc = to ? MAXW : n_ready;
    for (int k = 0; k < nacc; k++) begin
      e_req = 1; e_we = st; e_addr = {a[31:2], 2'b00}; e_be = mbe(sz, a); e_wdata = mwd(sz, d2);
      e_stall = 1;
      e_lit_be_on = lbe_on; e_lit_be = lbe; e_lit_wdata = lwd;
      dbus_ready = !to && (k == nacc - 1);
      dbus_rdata = dbus_ready ? rd : 32'h0;
      step();
    end
    dbus_ready = 0; dbus_rdata = 0;
    e_req = 0; e_stall = 0; e_lit_be_on = 0;
    e_berr = to;
    e_rf_we = ld && rw && (wa != 0) && !to;
    e_rf_waddr = wa;
    e_rf_wdata = mload(f3, a, rd);
    e_lit_wd_on = lw_on; e_lit_wd = lw_val;
    e_lit_st_on = 1; e_lit_st = lst;
    step();
  endtask

  task automatic alu_op(input logic [1:0] wb, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [4:0] wa, input logic rw, input logic lw_on, input logic [31:0] lw_val);
    clr_exp();
    idle_in();
    wb_sel_mw = wb; alu_result_mw = alu; pc_mw = pc; waddr_mw = wa; regwr_mw = rw;
    e_rf_we = rw && (wa != 0);
    e_rf_waddr = wa;
    e_rf_wdata = (wb == 2'd2) ? pc + 32'd4 : alu;
    e_lit_wd_on = lw_on; e_lit_wd = lw_val;
    step();
  endtask

  initial begin
    clr_exp();
    idle_in();
    rst = 1;
    // writes and a misaligned load are presented during reset and must be suppressed
    ld_mw = 1; funct3_mw = 3'b010; alu_result_mw = 32'h106; regwr_mw = 1; waddr_mw = 5'd3;
    step();
    e_on = 1; e_bus_zero = 1;
    step();
    rst = 0;

    // reset abandons an access in progress
    clr_exp();
    idle_in();
    ld_mw = 1; funct3_mw = 3'b010; alu_result_mw = 32'h100; waddr_mw = 5'd7; regwr_mw = 1; wb_sel_mw = 1;
    e_stall = 1;
    step();
    e_req = 1; e_we = 0; e_addr = 32'h100; e_be = 4'hF; e_wdata = 32'h0;
    step();
    step();
    idle_in();
    rst = 1;
    e_stall = 0;
    step();
    rst = 0;
    e_req = 0; e_bus_zero = 1;
    step();

    mem_op(1, 0, 3'b010, 32'h104, 0, 5'd5, 1, 3, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4, 0, 0, 0);
    mem_op(1, 0, 3'b000, 32'h203, 0, 5'd6, 1, 1, 32'h80FF_0000, 1, 32'hFFFF_FF80, 2, 0, 0, 0);
    mem_op(1, 0, 3'b100, 32'h203, 0, 5'd6, 1, 2, 32'h80FF_0000, 1, 32'h0000_0080, 3, 0, 0, 0);
    mem_op(1, 0, 3'b101, 32'h202, 0, 5'd8, 1, 1, 32'h80FF_0000, 1, 32'h0000_80FF, 2, 0, 0, 0);
    mem_op(1, 0, 3'b001, 32'h202, 0, 5'd8, 1, 1, 32'h80FF_0000, 1, 32'hFFFF_80FF, 2, 0, 0, 0);
    mem_op(0, 1, 3'b001, 32'h302, 32'h1234_ABCD, 5'd4, 1, 1, 0, 0, 0, 2, 1, 4'b1100, 32'hABCD_ABCD);
    mem_op(0, 1, 3'b000, 32'h301, 32'h0000_005A, 5'd0, 0, 2, 0, 0, 0, 3, 1, 4'b0010, 32'h5A5A_5A5A);
    mem_op(0, 1, 3'b010, 32'h308, 32'hCAFE_F00D, 5'd0, 0, 1, 0, 0, 0, 2, 1, 4'b1111, 32'hCAFE_F00D);
    mem_op(1, 0, 3'b010, 32'h106, 0, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    mem_op(1, 0, 3'b001, 32'h201, 0, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    alu_op(2'd0, 32'h0000_0055, 32'h0, 5'd0, 1, 0, 0);
    alu_op(2'd0, 32'h1357_9BDF, 32'h0, 5'd10, 1, 1, 32'h1357_9BDF);
    alu_op(2'd3, 32'h0000_0077, 32'h0, 5'd11, 1, 1, 32'h0000_0077);
    mem_op(1, 0, 3'b010, 32'h110, 0, 5'd9, 1, 0, 32'h0, 0, 0, 16, 0, 0, 0);
    alu_op(2'd2, 32'h1234, 32'hFFFF_FFFC, 5'd1, 1, 1, 32'h0000_0000);
    alu_op(2'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    e_on = 0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mw_load_store_unit.md
Name: mw_load_store_unit

Overview:
- Consumer end of the MW pipeline register in the 3-stage RV32I core.
- Takes the registered address (ALU result), store data, destination register and PC from the MW stage, and performs data-memory accesses over a req/ready bus.
- Formats load data and drives the register-file write port.
- Asserts stall to freeze the F and MW pipeline registers while a memory access is outstanding.

Parameters:
- MAX_WAIT, 15: maximum ACCESS cycles without dbus_ready before a bus timeout; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ld_mw  in  1  MW instruction is a load
- st_mw  in  1  MW instruction is a store
- funct3_mw  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- alu_result_mw  in  32  effective address, or ALU writeback value
- rdata2_mw  in  32  store data
- pc_mw  in  32  PC of the MW instruction
- waddr_mw  in  5  destination register
- regwr_mw  in  1  instruction writes the register file
- wb_sel_mw  in  2  writeback source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU)
- dbus_req  out  1  request valid (registered)
- dbus_we  out  1  write request
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata  out  32  lane-replicated store data
- dbus_be  out  4  byte enables
- dbus_rdata  in  32  read data, valid when dbus_req & dbus_ready
- dbus_ready  in  1  transfer completes this cycle
- stall  out  1  freeze F and MW registers
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address (= waddr_mw)
- rf_wdata  out  32  register-file write data
- misalign_exc  out  1  one-cycle misaligned-access flag
- bus_err  out  1  one-cycle timeout pulse (registered)

Behaviour:

Reset:
- State IDLE; wait counter 0; ld_data_q 0.
- dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be all 0; bus_err 0.
- While rst=1: stall=0, rf_we=0, misalign_exc=0.
- Reset during ACCESS drops dbus_req at the next edge; the bus must tolerate an abandoned request.

Misalignment:
- lw/sw misaligned: addr[1:0]!=0.
- lh/lhu/sh misaligned: addr[0]!=0.
- byte accesses are never misaligned.

FSM states: IDLE, ACCESS, DONE.
- IDLE, no ld/st:
  - stall=0.
  - rf_wdata selected by wb_sel_mw; PC+4 is pc_mw+4, mod 2^32.
- IDLE, ld|st and misaligned:
  - misalign_exc=1 (combinational), stall=0, rf_we=0, no bus activity, stay IDLE.
- IDLE, ld|st and aligned:
  - stall=1 this cycle.
  - Register dbus_req=1, dbus_we=st_mw, addr, be and wdata.
  - Next state ACCESS; counter cleared.
- ACCESS:
  - stall=1; bus outputs held stable until dbus_ready.
  - On dbus_ready: capture formatted dbus_rdata into ld_data_q, drop dbus_req and dbus_we next edge, go DONE.
  - Otherwise counter+1. When counter reaches MAX_WAIT-1 without ready: drop dbus_req, pulse bus_err for one cycle, set err flag, go DONE.
- DONE:
  - stall=0.
  - rf_we = regwr_mw & (waddr_mw!=0) & ld_mw & ~err.
  - rf_wdata = ld_data_q.
  - Always returns to IDLE; DONE never re-triggers an access for the same held instruction.

General rules:
- rf_we = regwr_mw & (waddr_mw!=0) & ~stall & ~misalign_exc.
- Stores never write the register file.
- Latency: a non-memory instruction retires in 1 cycle. A memory instruction retires in 1 + N + 1 cycles, where N ≥ 1 is the number of ACCESS cycles until ready. Minimum 2 stall cycles.

Store formatting:
- sb: be = 4'b0001 << addr[1:0]; wdata = {4{rdata2[7:0]}}.
- sh: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rdata2[15:0]}}.
- sw: be = 4'b1111; wdata = rdata2.
- Undefined funct3 on ld/st: treated as word.

Load formatting:
- Select the byte/halfword lane by addr[1:0].
- lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.

Test Plan:
- Reset mid-ACCESS (lw 0x100, ready held 0, rst pulsed) -> next cycle dbus_req=0, stall=0, state IDLE, rf_we=0.
- lw x5, addr 0x104, ready on 3rd ACCESS cycle with rdata 0xDEADBEEF -> stall high 4 cycles; DONE cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- lb addr 0x203, rdata 0x80FF_0000 -> rf_wdata 0xFFFFFF80; same with lbu -> 0x00000080; lhu addr 0x202 -> 0x000080FF.
- sh addr 0x302, rdata2 0x1234ABCD -> dbus_be 4'b1100, dbus_wdata 0xABCDABCD, dbus_we=1, rf_we=0 in DONE.
- lw addr 0x106 -> misalign_exc=1, stall=0, dbus_req stays 0, rf_we=0; ALU op x0 with regwr=1 -> rf_we=0.
- lw with dbus_ready never asserted, MAX_WAIT=15 -> stall high 16 cycles, dbus_req dropped after 15 ACCESS cycles, bus_err=1 for 1 cycle, rf_we=0 in DONE; jal-type wb_sel=2, pc_mw 0xFFFFFFFC -> rf_wdata 0x00000000.
